// File: rtl/test_mode_generator.sv
// rtl/test_mode_generator.sv - patterned test-word source with gap insertion, backpressure and error injection
//
// Ports:
//   clk        - single clock for all logic
//   rst_n      - asynchronous active-low reset
//   en         - generation enable (level)
//   gap        - idle cycles inserted between words, sampled when a word is emitted
//   full       - downstream FIFO full; stalls emission while high
//   inject_err - single-cycle request to invert bit 0 of the next emitted word
//   data       - test word, {8'h00, seq, 8'h00, seq+1}
//   rdy        - one-cycle write strobe qualifying data
//   word_cnt   - words emitted since the last start (wraps at 2^16)
//   wrap       - pulses with the word carrying seq = 8'hFD (last word of a pass)

module test_mode_generator (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [7:0]  gap,
    input  logic        full,
    input  logic        inject_err,
    output logic [31:0] data,
    output logic        rdy,
    output logic [15:0] word_cnt,
    output logic        wrap
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [7:0] SEQ_FIRST = 8'h01;
    localparam logic [7:0] SEQ_LAST  = 8'hFD;

    state_t      state;
    logic [7:0]  seq;
    logic [7:0]  gap_cnt;
    logic        err_pending;

    logic [7:0]  seq_plus1;
    logic [7:0]  seq_next;
    logic [31:0] word;

    // seq+1 wraps naturally in 8 bits; seq itself walks 01,05,...,FD and restarts.
    assign seq_plus1 = seq + 8'd1;
    assign seq_next  = (seq == SEQ_LAST) ? SEQ_FIRST : (seq + 8'd4);
    assign word      = {8'h00, seq, 8'h00, seq_plus1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rdy         <= 1'b0;
            data        <= 32'h0;
            word_cnt    <= 16'h0;
            wrap        <= 1'b0;
            seq         <= SEQ_FIRST;
            gap_cnt     <= 8'h0;
            err_pending <= 1'b0;
        end else begin
            // Strobes are single-cycle; they are only raised by an emission below.
            rdy  <= 1'b0;
            wrap <= 1'b0;

            // A request is latched in every state, including IDLE, and survives
            // until a word actually consumes it.
            if (inject_err) begin
                err_pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (en) begin
                        state    <= SEND;
                        seq      <= SEQ_FIRST;
                        word_cnt <= 16'h0;
                    end
                end

                SEND: begin
                    if (!en) begin
                        state <= IDLE;
                    end else if (!full) begin
                        rdy      <= 1'b1;
                        data     <= word ^ {31'h0, err_pending};
                        wrap     <= (seq == SEQ_LAST);
                        seq      <= seq_next;
                        word_cnt <= word_cnt + 16'd1;
                        // The pending flag is consumed by this word; a request
                        // arriving on the same edge is kept for the next one.
                        err_pending <= inject_err;
                        if (gap != 8'h0) begin
                            state   <= GAP;
                            gap_cnt <= gap;
                        end
                    end
                end

                GAP: begin
                    if (!en) begin
                        state   <= IDLE;
                        gap_cnt <= 8'h0;
                    end else begin
                        // Leaving on count 1 yields exactly 'gap' low cycles,
                        // since the SEND edge itself produces the next strobe.
                        if (gap_cnt == 8'd1) begin
                            state <= SEND;
                        end
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
